// File: rtl/alu_writeback_regfile.sv
// Writeback stage behind the ALU: a one-entry pending register that commits into
// a register file one edge later, with read bypass and a committed-write counter.
module alu_writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_alu_valid,
  input  logic              i_alu_we,
  input  logic [ADDR_W-1:0] i_alu_rd,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_stall,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  output logic              o_wb_pending,
  output logic [ADDR_W-1:0] o_wb_rd,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [CNT_W-1:0]  o_wr_count
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_wb_pending;
  logic [ADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic [CNT_W-1:0]  r_wr_count;

  logic              w_capture;
  logic              w_commit;
  logic              w_commit_writes;

  assign w_capture       = i_alu_valid & i_alu_we;
  assign w_commit        = r_wb_pending & ~i_stall;
  assign w_commit_writes = w_commit & (r_wb_rd != '0);

  // Commit of the older entry and capture of the newer one share the same edge;
  // reset drops any pending entry without committing it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_wb_pending <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_wr_count   <= '0;
    end else if (!i_stall) begin
      if (w_commit_writes) begin
        r_regs[r_wb_rd] <= r_wb_data;
      end
      if (w_commit) begin
        r_wr_count <= r_wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      r_wb_pending <= w_capture;
      if (w_capture) begin
        r_wb_rd   <= i_alu_rd;
        r_wb_data <= i_alu_result;
      end
    end
  end

  // Register 0 reads as zero even when a pending entry targets it.
  always_comb begin
    o_rs1_data = r_regs[i_rs1_addr];
    if (i_rs1_addr == '0) begin
      o_rs1_data = '0;
    end else if (r_wb_pending && (r_wb_rd == i_rs1_addr)) begin
      o_rs1_data = r_wb_data;
    end
  end

  always_comb begin
    o_rs2_data = r_regs[i_rs2_addr];
    if (i_rs2_addr == '0) begin
      o_rs2_data = '0;
    end else if (r_wb_pending && (r_wb_rd == i_rs2_addr)) begin
      o_rs2_data = r_wb_data;
    end
  end

  assign o_wb_pending = r_wb_pending;
  assign o_wb_rd      = r_wb_rd;
  assign o_wb_data    = r_wb_data;
  assign o_wr_count   = r_wr_count;

endmodule

// File: tb/tb_alu_writeback_regfile.sv
// Directed bench for alu_writeback_regfile: hand-computed expectations for capture,
// commit, bypass, stall, register-0 and reset behaviour.
module tb_alu_writeback_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        aluValid;
  logic        aluWe;
  logic [3:0]  aluRd;
  logic [31:0] aluResult;
  logic        stall;
  logic [3:0]  rs1Addr;
  logic [3:0]  rs2Addr;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        wbPending;
  logic [3:0]  wbRd;
  logic [31:0] wbData;
  logic [15:0] wrCount;

  int checkCount = 0;
  int passCount  = 0;

  alu_writeback_regfile dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_alu_valid  (aluValid),
    .i_alu_we     (aluWe),
    .i_alu_rd     (aluRd),
    .i_alu_result (aluResult),
    .i_stall      (stall),
    .i_rs1_addr   (rs1Addr),
    .i_rs2_addr   (rs2Addr),
    .o_rs1_data   (rs1Data),
    .o_rs2_data   (rs2Data),
    .o_wb_pending (wbPending),
    .o_wb_rd      (wbRd),
    .o_wb_data    (wbData),
    .o_wr_count   (wrCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [3:0] rd,
                               input logic [31:0] res, input logic st);
    aluValid  = v;
    aluWe     = we;
    aluRd     = rd;
    aluResult = res;
    stall     = st;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readPorts(input logic [3:0] a1, input logic [3:0] a2);
    rs1Addr = a1;
    rs2Addr = a2;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    rs1Addr = 4'd0;
    rs2Addr = 4'd0;

    tick();
    checkOutput("reset_pending", {31'b0, wbPending}, 32'h0);
    checkOutput("reset_count", {16'b0, wrCount}, 32'h0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    readPorts(4'd0, 4'd9);
    checkOutput("idle_rs1_r0", rs1Data, 32'h0);
    checkOutput("idle_rs2_r9", rs2Data, 32'h0);
    checkOutput("idle_pending", {31'b0, wbPending}, 32'h0);
    checkOutput("idle_count", {16'b0, wrCount}, 32'h0);
    checkOutput("idle_wbrd", {28'b0, wbRd}, 32'h0);
    checkOutput("idle_wbdata", wbData, 32'h0);

    // Single write to r3
    applyStimulus(1'b1, 1'b1, 4'd3, 32'h0000_00A5, 1'b0);
    tick();
    readPorts(4'd3, 4'd1);
    checkOutput("single_pending", {31'b0, wbPending}, 32'h1);
    checkOutput("single_wbrd", {28'b0, wbRd}, 32'h3);
    checkOutput("single_bypass", rs1Data, 32'h0000_00A5);
    checkOutput("single_other", rs2Data, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    tick();
    checkOutput("single_pending_clr", {31'b0, wbPending}, 32'h0);
    checkOutput("single_reg3", rs1Data, 32'h0000_00A5);
    checkOutput("single_count", {16'b0, wrCount}, 32'h1);

    // Back-to-back writes to r5
    applyStimulus(1'b1, 1'b1, 4'd5, 32'h11, 1'b0);
    tick();
    readPorts(4'd5, 4'd5);
    checkOutput("b2b_first_bypass", rs1Data, 32'h11);
    applyStimulus(1'b1, 1'b1, 4'd5, 32'h22, 1'b0);
    tick();
    checkOutput("b2b_rs1_bypass", rs1Data, 32'h22);
    checkOutput("b2b_rs2_same", rs2Data, 32'h22);
    checkOutput("b2b_count_mid", {16'b0, wrCount}, 32'h2);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    tick();
    checkOutput("b2b_pending_clr", {31'b0, wbPending}, 32'h0);
    checkOutput("b2b_reg5", rs1Data, 32'h22);
    checkOutput("b2b_count", {16'b0, wrCount}, 32'h3);

    // Stall holds the pending r7 entry while r8 is presented
    applyStimulus(1'b1, 1'b1, 4'd7, 32'h0000_DEAD, 1'b0);
    tick();
    readPorts(4'd7, 4'd8);
    applyStimulus(1'b1, 1'b1, 4'd8, 32'h0000_BEEF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_wbrd", {28'b0, wbRd}, 32'h7);
      checkOutput("stall_wbdata", wbData, 32'h0000_DEAD);
      checkOutput("stall_pending", {31'b0, wbPending}, 32'h1);
      checkOutput("stall_count", {16'b0, wrCount}, 32'h3);
      checkOutput("stall_r8_untouched", rs2Data, 32'h0);
    end
    stall = 1'b0;
    tick();
    checkOutput("unstall_reg7", rs1Data, 32'h0000_DEAD);
    checkOutput("unstall_wbrd", {28'b0, wbRd}, 32'h8);
    checkOutput("unstall_bypass8", rs2Data, 32'h0000_BEEF);
    checkOutput("unstall_count", {16'b0, wrCount}, 32'h4);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    tick();
    checkOutput("unstall_reg8", rs2Data, 32'h0000_BEEF);
    checkOutput("unstall_count2", {16'b0, wrCount}, 32'h5);

    // Register 0 writes, we=0 and we without valid
    applyStimulus(1'b1, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0);
    tick();
    readPorts(4'd0, 4'd2);
    checkOutput("r0_pending", {31'b0, wbPending}, 32'h1);
    checkOutput("r0_bypass_zero", rs1Data, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'd2, 32'h9, 1'b0);
    tick();
    checkOutput("r0_reads_zero", rs1Data, 32'h0);
    checkOutput("we0_pending", {31'b0, wbPending}, 32'h0);
    checkOutput("we0_reg2", rs2Data, 32'h0);
    checkOutput("r0_count", {16'b0, wrCount}, 32'h6);
    applyStimulus(1'b0, 1'b1, 4'd2, 32'h9, 1'b0);
    tick();
    checkOutput("novalid_pending", {31'b0, wbPending}, 32'h0);
    tick();
    checkOutput("novalid_reg2", rs2Data, 32'h0);
    checkOutput("novalid_r0", rs1Data, 32'h0);
    checkOutput("novalid_count", {16'b0, wrCount}, 32'h6);

    // Reset with an entry pending discards it and clears the file
    applyStimulus(1'b1, 1'b1, 4'd4, 32'h55, 1'b0);
    tick();
    readPorts(4'd4, 4'd3);
    checkOutput("midrst_bypass", rs1Data, 32'h55);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_pending", {31'b0, wbPending}, 32'h0);
    checkOutput("midrst_count", {16'b0, wrCount}, 32'h0);
    tick();
    checkOutput("midrst_reg4", rs1Data, 32'h0);
    checkOutput("midrst_reg3", rs2Data, 32'h0);
    checkOutput("midrst_count2", {16'b0, wrCount}, 32'h0);
    readPorts(4'd5, 4'd7);
    checkOutput("midrst_reg5", rs1Data, 32'h0);
    checkOutput("midrst_reg7", rs2Data, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
